// File: rtl/rv_fetch_queue.sv
// rv_fetch_queue - instruction prefetch queue for the multicycle RISC-V core.
//
// The queue keeps up to DEPTH fetch requests in flight. Each response from the
// in-order memory is stored together with its PC. Decode pops the oldest entry
// through a valid/ready handshake. A redirect flushes the queue and restarts
// fetch at a new PC. Responses that were already in flight at the redirect are
// counted, and they are dropped when they arrive.
//
// Ports:
//   clk, rst                 clock (rising edge), asynchronous active-low reset
//   mem_req_valid/ready      fetch request handshake
//   mem_req_addr             word address of the request (PC[ADDR_W-1:2])
//   mem_rsp_valid/data       in-order response, one per accepted request
//   redirect, redirect_pc    one-cycle flush pulse and new fetch byte address
//   instr_valid/ready        queue head handshake towards decode
//   instr, instr_pc          head instruction and its byte PC
//   outstanding              accepted requests not yet answered (incl. discards)
module rv_fetch_queue #(
  parameter int                XLEN     = 32,
  parameter int                ADDR_W   = 32,
  parameter int                DEPTH    = 4,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic                    clk,
  input  logic                    rst,
  output logic                    mem_req_valid,
  input  logic                    mem_req_ready,
  output logic [ADDR_W-3:0]       mem_req_addr,
  input  logic                    mem_rsp_valid,
  input  logic [XLEN-1:0]         mem_rsp_data,
  input  logic                    redirect,
  input  logic [ADDR_W-1:0]       redirect_pc,
  output logic                    instr_valid,
  input  logic                    instr_ready,
  output logic [XLEN-1:0]         instr,
  output logic [ADDR_W-1:0]       instr_pc,
  output logic [$clog2(DEPTH):0]  outstanding
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam int WW = ADDR_W - 2;
  localparam logic [WW-1:0] RESET_WORD  = RESET_PC[ADDR_W-1:2];
  localparam logic [CW:0]   DEPTH_LIMIT = (CW+1)'(DEPTH);

  // PCs are kept as word addresses. The byte-offset bits are always zero.
  logic [WW-1:0]   fetch_pc_reg, fetch_pc_next;
  logic [WW-1:0]   rsp_pc_reg, rsp_pc_next;
  logic [CW-1:0]   count_reg, count_next;
  logic [CW-1:0]   outstanding_reg, outstanding_next;
  logic [CW-1:0]   discard_reg, discard_next;
  logic [PW-1:0]   head_reg, head_next;
  logic [PW-1:0]   tail_reg, tail_next;
  logic [XLEN-1:0] instr_reg, instr_next;
  logic [WW-1:0]   instr_pc_reg, instr_pc_next;

  logic [XLEN-1:0] data_mem [DEPTH];
  logic [WW-1:0]   pc_mem   [DEPTH];

  logic credit_ok;
  logic req_fire;
  logic wr_en;
  logic pop;
  logic unused_redirect_lsbs;

  assign unused_redirect_lsbs = ^redirect_pc[1:0];

  // A new request is issued only if its response is sure to have a free
  // slot, counting both the queued entries and the requests in flight.
  assign credit_ok     = ({1'b0, count_reg} + {1'b0, outstanding_reg}) < DEPTH_LIMIT;
  assign mem_req_valid = rst & ~redirect & credit_ok;
  assign mem_req_addr  = fetch_pc_reg;
  assign req_fire      = mem_req_valid & mem_req_ready;

  assign instr_valid = (count_reg != '0);
  assign instr       = instr_reg;
  assign instr_pc    = {instr_pc_reg, 2'b00};
  assign outstanding = outstanding_reg;

  // A response is stored only when it is not stale.
  assign wr_en = mem_rsp_valid & ~redirect & (discard_reg == '0);
  assign pop   = instr_valid & instr_ready & ~redirect;

  always_comb begin
    fetch_pc_next    = fetch_pc_reg + WW'(req_fire);
    rsp_pc_next      = rsp_pc_reg + WW'(wr_en);
    count_next       = count_reg + CW'(wr_en) - CW'(pop);
    outstanding_next = outstanding_reg + CW'(req_fire) - CW'(mem_rsp_valid);
    discard_next     = discard_reg - CW'(mem_rsp_valid && (discard_reg != '0));
    head_next        = head_reg + PW'(pop);
    tail_next        = tail_reg + PW'(wr_en);
    instr_next       = instr_reg;
    instr_pc_next    = instr_pc_reg;

    if (redirect) begin
      fetch_pc_next = redirect_pc[ADDR_W-1:2];
      rsp_pc_next   = redirect_pc[ADDR_W-1:2];
      count_next    = '0;
      head_next     = '0;
      tail_next     = '0;
      // Every request still in flight becomes stale. A response that arrives
      // in this cycle is already dropped, so it does not count.
      discard_next  = outstanding_reg - CW'(mem_rsp_valid);
    end else if (count_next != '0) begin
      // The head registers load the entry that will be at the head next
      // cycle. If the queue would otherwise be empty, that entry is the one
      // being written now, so it is taken straight from the response.
      if (wr_en && (head_next == tail_reg)) begin
        instr_next    = mem_rsp_data;
        instr_pc_next = rsp_pc_reg;
      end else begin
        instr_next    = data_mem[head_next];
        instr_pc_next = pc_mem[head_next];
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      fetch_pc_reg    <= RESET_WORD;
      rsp_pc_reg      <= RESET_WORD;
      count_reg       <= '0;
      outstanding_reg <= '0;
      discard_reg     <= '0;
      head_reg        <= '0;
      tail_reg        <= '0;
      instr_reg       <= '0;
      instr_pc_reg    <= RESET_WORD;
    end else begin
      fetch_pc_reg    <= fetch_pc_next;
      rsp_pc_reg      <= rsp_pc_next;
      count_reg       <= count_next;
      outstanding_reg <= outstanding_next;
      discard_reg     <= discard_next;
      head_reg        <= head_next;
      tail_reg        <= tail_next;
      instr_reg       <= instr_next;
      instr_pc_reg    <= instr_pc_next;
    end
  end

  // Queue storage has no reset. Only entries between head and tail are read.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      data_mem[tail_reg] <= mem_rsp_data;
      pc_mem[tail_reg]   <= rsp_pc_reg;
    end
  end

endmodule

// File: tb/tb_rv_fetch_queue.sv
module tb_rv_fetch_queue;
  localparam int DEPTH = 4;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] data;
  } ent_t;

  typedef struct {
    logic [29:0] addr;
    int          due;
  } pend_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst = 1'b0;
  logic        mem_req_valid;
  logic        mem_req_ready = 1'b0;
  logic [29:0] mem_req_addr;
  logic        mem_rsp_valid = 1'b0;
  logic [31:0] mem_rsp_data = '0;
  logic        redirect = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic        instr_valid;
  logic        instr_ready = 1'b0;
  logic [31:0] instr;
  logic [31:0] instr_pc;
  logic [2:0]  outstanding;

  rv_fetch_queue #(.XLEN(32), .ADDR_W(32), .DEPTH(DEPTH), .RESET_PC(32'h0)) u_dut (
    .clk(clk), .rst(rst),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_req_addr(mem_req_addr),
    .mem_rsp_valid(mem_rsp_valid), .mem_rsp_data(mem_rsp_data),
    .redirect(redirect), .redirect_pc(redirect_pc),
    .instr_valid(instr_valid), .instr_ready(instr_ready), .instr(instr), .instr_pc(instr_pc),
    .outstanding(outstanding)
  );

  // Second instance: reset PC near the top of the address space, always-ready
  // 1-cycle memory, decode always ready.
  logic        w_req_valid;
  logic [29:0] w_req_addr;
  logic        w_rsp_valid = 1'b0;
  logic [31:0] w_rsp_data = '0;
  logic        w_instr_valid;
  logic [31:0] w_instr;
  logic [31:0] w_instr_pc;
  logic [2:0]  w_outstanding;

  rv_fetch_queue #(.XLEN(32), .ADDR_W(32), .DEPTH(DEPTH), .RESET_PC(32'hFFFF_FFF8)) u_dut_wrap (
    .clk(clk), .rst(rst),
    .mem_req_valid(w_req_valid), .mem_req_ready(1'b1), .mem_req_addr(w_req_addr),
    .mem_rsp_valid(w_rsp_valid), .mem_rsp_data(w_rsp_data),
    .redirect(1'b0), .redirect_pc(32'h0),
    .instr_valid(w_instr_valid), .instr_ready(1'b1), .instr(w_instr), .instr_pc(w_instr_pc),
    .outstanding(w_outstanding)
  );

  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h at cycle %0d", name, act, exp, cyc);
  endtask

  // Behavioural model: the queue is a list of delivered entries. Fetch
  // bookkeeping is a few integers. The memory is a list of pending responses.
  logic [29:0] m_fetch = '0;
  logic [29:0] m_rsp   = '0;
  int          m_out   = 0;
  int          m_disc  = 0;
  ent_t        m_q[$];
  pend_t       pend[$];
  int          lat_min = 1;
  int          lat_max = 1;

  // Observations of the DUT, used by the directed literal checks.
  logic [29:0] obs_req_addrs[$];
  int          obs_fire_cyc[$];
  ent_t        obs_pops[$];
  int          obs_first_valid_cyc = -1;
  logic        obs_rv, obs_iv;
  logic [2:0]  obs_out;
  logic [29:0] obs_addr;
  bit          hit = 1'b0;

  task automatic clear_obs();
    obs_req_addrs.delete();
    obs_fire_cyc.delete();
    obs_pops.delete();
    obs_first_valid_cyc = -1;
  endtask

  task automatic model_reset();
    m_fetch = '0;
    m_rsp   = '0;
    m_out   = 0;
    m_disc  = 0;
    m_q.delete();
    pend.delete();
  endtask

  task automatic cycle(input bit rdy, input bit irdy, input bit redir, input logic [31:0] rpc,
                       input bit auto_redir);
    bit          rsp, exp_rv, exp_iv, fire, pop;
    logic [29:0] raddr;
    ent_t        e;
    pend_t       p;
    @(negedge clk);
    rsp   = (pend.size() > 0) && (pend[0].due <= cyc);
    raddr = rsp ? pend[0].addr : 30'h0;
    if (auto_redir && !hit && rsp && irdy && (m_q.size() > 0) && (m_out == 2) && (m_disc == 0)) begin
      redir = 1'b1;
      rpc   = 32'h200;
      hit   = 1'b1;
    end
    mem_req_ready = rdy;
    instr_ready   = irdy;
    redirect      = redir;
    redirect_pc   = rpc;
    mem_rsp_valid = rsp;
    mem_rsp_data  = rsp ? {2'b00, raddr} : $urandom;
    #1;
    exp_rv = !redir && ((m_q.size() + m_out) < DEPTH);
    exp_iv = (m_q.size() != 0);
    chk("req_valid", 64'(mem_req_valid), 64'(exp_rv));
    if (exp_rv) chk("req_addr", 64'(mem_req_addr), 64'(m_fetch));
    chk("instr_valid", 64'(instr_valid), 64'(exp_iv));
    if (exp_iv) begin
      chk("instr", 64'(instr), 64'(m_q[0].data));
      chk("instr_pc", 64'(instr_pc), 64'(m_q[0].pc));
    end
    chk("outstanding", 64'(outstanding), 64'(m_out));

    obs_rv   = mem_req_valid;
    obs_iv   = instr_valid;
    obs_out  = outstanding;
    obs_addr = mem_req_addr;
    if (mem_req_valid && rdy) begin
      obs_req_addrs.push_back(mem_req_addr);
      obs_fire_cyc.push_back(cyc);
    end
    if (instr_valid && obs_first_valid_cyc < 0) obs_first_valid_cyc = cyc;
    if (instr_valid && irdy && !redir) begin
      e.pc   = instr_pc;
      e.data = instr;
      obs_pops.push_back(e);
      $display("cycle %0d: deliver pc=0x%08h instr=0x%08h", cyc, instr_pc, instr);
    end
    if (redir) $display("cycle %0d: redirect to 0x%08h", cyc, rpc);

    fire = exp_rv && rdy;
    pop  = exp_iv && irdy && !redir;
    if (rsp) p = pend.pop_front();
    if (redir) begin
      m_q.delete();
      if (rsp) m_out--;
      m_disc  = m_out;
      m_fetch = rpc[31:2];
      m_rsp   = rpc[31:2];
    end else begin
      if (rsp && m_disc == 0)
        assert (m_q.size() < DEPTH) else $error("FAIL rsp_room: response to a full queue at cycle %0d", cyc);
      if (pop) e = m_q.pop_front();
      if (rsp) begin
        m_out--;
        if (m_disc > 0) m_disc--;
        else begin
          e.pc   = {m_rsp, 2'b00};
          e.data = {2'b00, raddr};
          m_q.push_back(e);
          m_rsp++;
        end
      end
      if (fire) begin
        p.addr = m_fetch;
        p.due  = cyc + $urandom_range(lat_max, lat_min);
        pend.push_back(p);
        m_out++;
        m_fetch++;
      end
    end
    cyc++;
  endtask

  task automatic do_reset(input bit precheck);
    @(negedge clk);
    if (precheck) begin
      chk("pre_rst_outstanding", 64'(outstanding), 64'(2));
      chk("pre_rst_instr_valid", 64'(instr_valid), 64'(1));
    end
    #2;
    rst = 1'b0;
    #1;
    chk("rst_req_valid", 64'(mem_req_valid), 64'(0));
    chk("rst_instr_valid", 64'(instr_valid), 64'(0));
    chk("rst_instr", 64'(instr), 64'(0));
    chk("rst_instr_pc", 64'(instr_pc), 64'(32'h0));
    chk("rst_outstanding", 64'(outstanding), 64'(0));
    chk("rst_wrap_instr_pc", 64'(w_instr_pc), 64'(32'hFFFF_FFF8));
    mem_req_ready = 1'b0;
    instr_ready   = 1'b0;
    redirect      = 1'b0;
    redirect_pc   = '0;
    mem_rsp_valid = 1'b0;
    repeat (2) @(posedge clk);
    model_reset();
    @(negedge clk);
    rst = 1'b1;
  endtask

  // Memory for the wrap instance: answers every request one cycle later.
  logic [31:0] w_pcs[$];
  logic [31:0] w_ins[$];
  logic        w_pending = 1'b0;
  logic [29:0] w_pend_addr = '0;
  initial begin
    forever begin
      @(negedge clk);
      w_rsp_valid = w_pending;
      w_rsp_data  = {2'b00, w_pend_addr};
      #1;
      w_pending   = w_req_valid;
      w_pend_addr = w_req_addr;
      if (rst && w_instr_valid && w_pcs.size() < 3) begin
        w_pcs.push_back(w_instr_pc);
        w_ins.push_back(w_instr);
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] wexp[3];
    wexp[0] = 32'hFFFF_FFF8;
    wexp[1] = 32'hFFFF_FFFC;
    wexp[2] = 32'h0000_0000;

    do_reset(1'b0);

    // Streaming fetch from a 1-cycle memory.
    lat_min = 1; lat_max = 1;
    clear_obs();
    repeat (12) cycle(1'b1, 1'b1, 1'b0, 32'h0, 1'b0);
    chk("t1_nreq_ge4", 64'(obs_req_addrs.size() >= 4), 64'(1));
    if (obs_req_addrs.size() >= 4)
      for (int i = 0; i < 4; i++) chk("t1_req_addr", 64'(obs_req_addrs[i]), 64'(i));
    chk("t1_npop_ge3", 64'(obs_pops.size() >= 3), 64'(1));
    if (obs_pops.size() >= 3)
      for (int i = 0; i < 3; i++) begin
        chk("t1_pop_pc", 64'(obs_pops[i].pc), 64'(4 * i));
        chk("t1_pop_instr", 64'(obs_pops[i].data), 64'(i));
      end
    if (obs_fire_cyc.size() > 0 && obs_first_valid_cyc >= 0)
      chk("t1_first_valid_latency", 64'(obs_first_valid_cyc - obs_fire_cyc[0]), 64'(2));
    else
      chk("t1_first_valid_seen", 64'(0), 64'(1));

    // Decode stalled: credit limits fetch to DEPTH requests.
    do_reset(1'b0);
    clear_obs();
    repeat (12) cycle(1'b1, 1'b0, 1'b0, 32'h0, 1'b0);
    chk("t2_nreq", 64'(obs_req_addrs.size()), 64'(4));
    chk("t2_req_valid_low", 64'(obs_rv), 64'(0));
    chk("t2_outstanding_zero", 64'(obs_out), 64'(0));
    chk("t2_instr_valid", 64'(obs_iv), 64'(1));
    clear_obs();
    cycle(1'b1, 1'b1, 1'b0, 32'h0, 1'b0);
    repeat (8) cycle(1'b1, 1'b0, 1'b0, 32'h0, 1'b0);
    chk("t2_one_more_req", 64'(obs_req_addrs.size()), 64'(1));

    // Redirect with three slow responses in flight.
    do_reset(1'b0);
    lat_min = 5; lat_max = 5;
    repeat (3) cycle(1'b1, 1'b1, 1'b0, 32'h0, 1'b0);
    cycle(1'b0, 1'b1, 1'b1, 32'h0000_0103, 1'b0);
    clear_obs();
    cycle(1'b1, 1'b1, 1'b0, 32'h0, 1'b0);
    chk("t3_req_valid_after_redirect", 64'(obs_rv), 64'(1));
    chk("t3_req_addr_after_redirect", 64'(obs_addr), 64'(30'h40));
    for (int i = 0; i < 40 && obs_pops.size() == 0; i++) cycle(1'b1, 1'b1, 1'b0, 32'h0, 1'b0);
    chk("t3_pop_seen", 64'(obs_pops.size() > 0), 64'(1));
    if (obs_pops.size() > 0) begin
      chk("t3_first_pc", 64'(obs_pops[0].pc), 64'(32'h100));
      chk("t3_first_instr", 64'(obs_pops[0].data), 64'(32'h40));
    end

    // Redirect coinciding with a response and a pop, two requests in flight.
    do_reset(1'b0);
    lat_min = 1; lat_max = 4;
    hit = 1'b0;
    for (int i = 0; i < 3000 && !hit; i++)
      cycle($urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1, 1'b0, 32'h0, 1'b1);
    chk("t4_condition_reached", 64'(hit), 64'(1));
    if (hit) begin
      clear_obs();
      cycle(1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
      chk("t4_queue_empty", 64'(obs_iv), 64'(0));
      chk("t4_outstanding", 64'(obs_out), 64'(1));
      for (int i = 0; i < 40 && obs_pops.size() == 0; i++) cycle(1'b1, 1'b1, 1'b0, 32'h0, 1'b0);
      chk("t4_pop_seen", 64'(obs_pops.size() > 0), 64'(1));
      if (obs_pops.size() > 0) chk("t4_first_pc", 64'(obs_pops[0].pc), 64'(32'h200));
    end

    // Randomised traffic with occasional redirects.
    lat_min = 1; lat_max = 6;
    for (int i = 0; i < 3000; i++)
      cycle($urandom_range(0, 9) < 7, $urandom_range(0, 9) < 6, $urandom_range(0, 99) < 3,
            $urandom, 1'b0);

    // Reset asserted with two requests in flight and one queued entry.
    do_reset(1'b0);
    lat_min = 2; lat_max = 2;
    for (int i = 0; i < 20; i++) begin
      cycle(1'b1, 1'b0, 1'b0, 32'h0, 1'b0);
      if (m_out == 2 && m_q.size() == 1) break;
    end
    do_reset(1'b1);
    clear_obs();
    cycle(1'b1, 1'b1, 1'b0, 32'h0, 1'b0);
    chk("restart_req_valid", 64'(obs_rv), 64'(1));
    chk("restart_req_addr", 64'(obs_addr), 64'(0));
    repeat (6) cycle(1'b1, 1'b1, 1'b0, 32'h0, 1'b0);

    // PC wrap on the second instance.
    chk("wrap_npc", 64'(w_pcs.size()), 64'(3));
    for (int i = 0; i < 3 && i < w_pcs.size(); i++) begin
      chk("wrap_pc", 64'(w_pcs[i]), 64'(wexp[i]));
      chk("wrap_instr", 64'(w_ins[i]), 64'({2'b00, wexp[i][31:2]}));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
